// File: rtl/matrix_alu_sched.sv
// Round-robin scheduler sharing one matrix_alu between two requesters.
// It accepts one command at a time, steps through the ALU's one-cycle
// registered latency, captures the result and returns it over a
// valid/ready response channel, tagged with the requester ID.
module matrix_alu_sched #(
  parameter int word_size     = 8,
  parameter int Amatrixrownum = 2,
  parameter int Amatrixcolnum = 2,
  parameter int Bmatrixrownum = 2,
  parameter int Bmatrixcolnum = 2
) (
  input  logic                                  clk,
  input  logic                                  resetn,
  input  logic                                  req0_valid,
  output logic                                  req0_ready,
  input  logic [1:0]                            req0_op,
  input  logic [Amatrixrownum*Amatrixcolnum*word_size-1:0] req0_A,
  input  logic [Bmatrixrownum*Bmatrixcolnum*word_size-1:0] req0_B,
  input  logic                                  req1_valid,
  output logic                                  req1_ready,
  input  logic [1:0]                            req1_op,
  input  logic [Amatrixrownum*Amatrixcolnum*word_size-1:0] req1_A,
  input  logic [Bmatrixrownum*Bmatrixcolnum*word_size-1:0] req1_B,
  output logic [1:0]                            alu_op,
  output logic [Amatrixrownum*Amatrixcolnum*word_size-1:0] alu_A,
  output logic [Bmatrixrownum*Bmatrixcolnum*word_size-1:0] alu_B,
  input  logic [Amatrixrownum*Amatrixcolnum*Bmatrixrownum*Bmatrixcolnum*word_size-1:0] alu_C,
  output logic                                  rsp_valid,
  input  logic                                  rsp_ready,
  output logic                                  rsp_id,
  output logic [Amatrixrownum*Amatrixcolnum*Bmatrixrownum*Bmatrixcolnum*word_size-1:0] rsp_C,
  output logic                                  busy,
  output logic [15:0]                           done_cnt
);

  localparam int AW = Amatrixrownum * Amatrixcolnum * word_size;
  localparam int BW = Bmatrixrownum * Bmatrixcolnum * word_size;
  localparam int CW = Amatrixrownum * Amatrixcolnum * Bmatrixrownum * Bmatrixcolnum * word_size;
  localparam int RW = Amatrixrownum * Bmatrixcolnum * word_size;

  // Ones over the RW result bits that add/sub/mul actually drive.
  localparam logic [CW-1:0] LOW_MASK = {CW{1'b1}} >> (CW - RW);

  localparam logic [1:0] OP_KRON = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    CAPT = 2'd2,
    RESP = 2'd3
  } state_t;

  state_t state;
  logic   prio;     // requester that wins a tie: the one not served last
  logic   cur_id;   // requester owning the command in flight
  logic   grant;    // requester picked this cycle when in IDLE
  logic   any_valid;

  // Only Kronecker drives the full CW bits; other ops leave the upper
  // part undriven, so it is cleared before it reaches the client.
  function automatic logic [CW-1:0] sanitise(input logic [1:0] op,
                                             input logic [CW-1:0] c);
    logic [CW-1:0] r;
    r = c;
    if (op != OP_KRON) r = c & LOW_MASK;
    return r;
  endfunction

  // Arbitration: a lone requester wins; on a tie the priority pointer decides.
  always_comb begin
    grant = 1'b0;
    if (req0_valid && req1_valid) grant = prio;
    else if (req1_valid)          grant = 1'b1;
  end

  assign any_valid  = req0_valid | req1_valid;
  assign req0_ready = (state == IDLE) && req0_valid && !grant;
  assign req1_ready = (state == IDLE) && req1_valid &&  grant;

  // Command sequencing FSM: accept, let the ALU register, capture, respond.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state     <= IDLE;
      prio      <= 1'b0;
      cur_id    <= 1'b0;
      alu_op    <= '0;
      alu_A     <= '0;
      alu_B     <= '0;
      rsp_C     <= '0;
      rsp_id    <= 1'b0;
      rsp_valid <= 1'b0;
      busy      <= 1'b0;
      done_cnt  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (any_valid) begin
            alu_op <= grant ? req1_op : req0_op;
            alu_A  <= grant ? req1_A  : req0_A;
            alu_B  <= grant ? req1_B  : req0_B;
            cur_id <= grant;
            busy   <= 1'b1;
            state  <= EXEC;
          end
        end
        EXEC: begin
          state <= CAPT;
        end
        CAPT: begin
          rsp_C     <= sanitise(alu_op, alu_C);
          rsp_id    <= cur_id;
          rsp_valid <= 1'b1;
          state     <= RESP;
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            done_cnt  <= done_cnt + 16'd1;
            prio      <= ~rsp_id;
            busy      <= 1'b0;
            state     <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
